add_sub_4bit: RTL and testbench

- 4-bit signed (two's-complement) adder/subtractor.
- Computes A+B when sub=0 and A−B when sub=1, with a signed overflow flag and a raw carry-out.
- Datapath is a ripple-carry chain of full adders; results are registered with a one-cycle latency.
- Used as the ALU arithmetic leaf in the datapath.

---
 rtl/add_sub_4bit.sv | 65 ++++++
 tb/tb_add_sub_4bit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/add_sub_4bit.sv
// 4-bit two's-complement adder/subtractor: ripple-carry core feeding one
// register stage, with signed-overflow and raw carry-out flags.
module add_sub_4bit (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       sub,
   input  logic       in_valid,
   output logic [3:0] sum,
   output logic       ovfl,
   output logic       cout,
   output logic       out_valid
);

   // Returns {carry_out, sum_bit} of one full-adder cell.
   function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
      full_add = {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
   endfunction

   logic        [3:0] bb_p0;
   logic signed [3:0] s_p0;
   logic        [4:0] c_p0;
   logic              ovfl_p0;

   // Stage p0: operand conditioning and ripple-carry chain
   always_comb begin
      bb_p0   = B ^ {4{sub}};
      s_p0    = '0;
      c_p0    = '0;
      c_p0[0] = sub;
      for (int i = 0; i < 4; i++) begin
         {c_p0[i+1], s_p0[i]} = full_add(A[i], bb_p0[i], c_p0[i]);
      end
      ovfl_p0 = c_p0[3] ^ c_p0[4];
   end

   logic signed [3:0] sum_p1;
   logic              ovfl_p1;
   logic              cout_p1;
   logic              vld_p1;

   // Stage p1: result register, loaded only on accepted operands
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_p1  <= '0;
         ovfl_p1 <= 1'b0;
         cout_p1 <= 1'b0;
         vld_p1  <= 1'b0;
      end else begin
         vld_p1 <= in_valid;
         if (in_valid) begin
            sum_p1  <= s_p0;
            ovfl_p1 <= ovfl_p0;
            cout_p1 <= c_p0[4];
         end
      end
   end

   assign sum       = sum_p1;
   assign ovfl      = ovfl_p1;
   assign cout      = cout_p1;
   assign out_valid = vld_p1;

endmodule

// File: tb/tb_add_sub_4bit.sv
// Self-checking bench for add_sub_4bit: directed cases, boundary sweep,
// reset behaviour and randomized operands against an integer model.
module tb_add_sub_4bit;

   logic       clk;
   logic       rst_n;
   logic [3:0] A;
   logic [3:0] B;
   logic       sub;
   logic       in_valid;
   logic [3:0] sum;
   logic       ovfl;
   logic       cout;
   logic       out_valid;

   int checks = 0;
   int errors = 0;

   add_sub_4bit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .A         (A),
      .B         (B),
      .sub       (sub),
      .in_valid  (in_valid),
      .sum       (sum),
      .ovfl      (ovfl),
      .cout      (cout),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer arithmetic on the signed/unsigned operand values.
   function automatic void ref_model(input logic [3:0] a, input logic [3:0] b, input logic s,
                                     output logic [3:0] es, output logic eo, output logic ec);
      int sa, sb, t;
      sa = $signed(a);
      sb = $signed(b);
      t  = s ? (sa - sb) : (sa + sb);
      es = t[3:0];
      eo = (t < -8) || (t > 7);
      ec = s ? (int'(a) >= int'(b)) : ((int'(a) + int'(b)) > 15);
   endfunction

   task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic s,
                         output logic [3:0] o_sum, output logic o_ov,
                         output logic o_co, output logic o_vld);
      @(negedge clk);
      A = a; B = b; sub = s; in_valid = 1'b1;
      @(posedge clk);
      #1;
      o_sum = sum; o_ov = ovfl; o_co = cout; o_vld = out_valid;
   endtask

   task automatic go_idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; A = '0; B = '0; sub = 1'b0; in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({sum, ovfl, cout, out_valid} !== 7'b0) begin
         errors++;
         $display("FAIL reset_state: got sum=%b ovfl=%b cout=%b vld=%b, want all 0", sum, ovfl, cout, out_valid);
      end
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [3:0] a_t [6] = '{4'd3, 4'd7, 4'b1000, 4'b0000, 4'd5, 4'b1101};
      logic [3:0] b_t [6] = '{4'd4, 4'd1, 4'b0001, 4'b1000, 4'd5, 4'b1100};
      logic       s_t [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [3:0] es_t[6] = '{4'b0111, 4'b1000, 4'b0111, 4'b1000, 4'b0000, 4'b1001};
      logic       eo_t[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic       ec_t[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [3:0] os;
      logic       oo, oc, ov;
      for (int i = 0; i < 6; i++) begin
         run_op(a_t[i], b_t[i], s_t[i], os, oo, oc, ov);
         checks++;
         if ({os, oo, oc, ov} !== {es_t[i], eo_t[i], ec_t[i], 1'b1}) begin
            errors++;
            $display("FAIL directed_%0d: got sum=%b ovfl=%b cout=%b vld=%b, want sum=%b ovfl=%b cout=%b vld=1",
                     i, os, oo, oc, ov, es_t[i], eo_t[i], ec_t[i]);
         end
      end
      go_idle();
   endtask

   task automatic test_hold();
      logic [3:0] os, es;
      logic       oo, oc, ov, eo, ec;
      run_op(4'd6, 4'd2, 1'b1, os, oo, oc, ov);
      ref_model(4'd6, 4'd2, 1'b1, es, eo, ec);
      @(negedge clk);
      in_valid = 1'b0;
      A = 4'd9; B = 4'd9; sub = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if ({sum, ovfl, cout, out_valid} !== {es, eo, ec, 1'b0}) begin
         errors++;
         $display("FAIL hold_idle: got sum=%b ovfl=%b cout=%b vld=%b, want sum=%b ovfl=%b cout=%b vld=0",
                  sum, ovfl, cout, out_valid, es, eo, ec);
      end
   endtask

   task automatic test_min_neg_sub();
      logic [3:0] os, es;
      logic       oo, oc, ov, eo, ec;
      for (int i = 0; i < 16; i++) begin
         run_op(4'(i), 4'b1000, 1'b1, os, oo, oc, ov);
         ref_model(4'(i), 4'b1000, 1'b1, es, eo, ec);
         checks++;
         if ({os, oo, oc, ov} !== {es, eo, ec, 1'b1} || oo !== (i < 8)) begin
            errors++;
            $display("FAIL min_neg_sub A=%0d: got sum=%b ovfl=%b cout=%b vld=%b, want sum=%b ovfl=%b cout=%b vld=1",
                     i, os, oo, oc, ov, es, eo, ec);
         end
      end
      go_idle();
   endtask

   task automatic test_async_reset();
      logic [3:0] os;
      logic       oo, oc, ov;
      run_op(4'd3, 4'd4, 1'b0, os, oo, oc, ov);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({sum, ovfl, cout, out_valid} !== 7'b0) begin
         errors++;
         $display("FAIL async_reset_clear: got sum=%b ovfl=%b cout=%b vld=%b, want all 0", sum, ovfl, cout, out_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if ({sum, out_valid} !== 5'b0) begin
         errors++;
         $display("FAIL post_reset_idle: got sum=%b vld=%b, want sum=0000 vld=0", sum, out_valid);
      end
   endtask

   task automatic test_random();
      logic [3:0] a, b, os, es;
      logic       s, oo, oc, ov, eo, ec;
      for (int i = 0; i < 100; i++) begin
         a = 4'($urandom_range(0, 15));
         b = 4'($urandom_range(0, 15));
         s = 1'($urandom_range(0, 1));
         run_op(a, b, s, os, oo, oc, ov);
         ref_model(a, b, s, es, eo, ec);
         checks++;
         if ({os, oo, oc, ov} !== {es, eo, ec, 1'b1}) begin
            errors++;
            $display("FAIL random_%0d A=%b B=%b sub=%b: got sum=%b ovfl=%b cout=%b vld=%b, want sum=%b ovfl=%b cout=%b vld=1",
                     i, a, b, s, os, oo, oc, ov, es, eo, ec);
         end
      end
      go_idle();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_hold();
      test_min_neg_sub();
      test_async_reset();
      test_random();
      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
